// File: rtl/cyclic74_pkg.sv
// ---------------------------------------------------------------------------
// cyclic74_pkg
// Shared constants, types and helpers for the (7,4) cyclic code with
// generator g(x) = 1 + x + x^3.
//   N, K      : code length and message length
//   G_LOW     : generator coefficients for x^0..x^2
//   SYN_X6    : syndrome produced by a single error at x^6 (the c6 position)
//   syn_t     : 3-bit syndrome type
//   lfsr_step : one step of the syndrome divider register
// ---------------------------------------------------------------------------
package cyclic74_pkg;

   localparam int          N      = 7;
   localparam int          K      = 4;
   localparam logic [2:0]  G_LOW  = 3'b011;
   localparam logic [2:0]  SYN_X6 = 3'b101;

   typedef logic [2:0] syn_t;

   // One divider step: feedback is the top stage, folded in through g(x).
   function automatic syn_t lfsr_step(input syn_t syn, input logic in_bit);
      syn_t shifted;
      shifted = {syn[1:0], in_bit};
      if (syn[2]) begin
         return shifted ^ G_LOW;
      end else begin
         return shifted;
      end
   endfunction

endpackage

// File: rtl/cyclic74_syndrome.sv
// ---------------------------------------------------------------------------
// cyclic74_syndrome
// 3-bit serial divider register for g(x) = 1 + x + x^3.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : shift one input bit into the divider
//   clr      : clear the register (has priority over en)
//   din      : serial input bit
//   syn_next : syndrome after accepting din this cycle (combinational)
// ---------------------------------------------------------------------------
module cyclic74_syndrome
   import cyclic74_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic       din,
   output logic [2:0] syn_next
);

   syn_t syn_r;
   syn_t syn_next_s;

   // Next syndrome assuming din is accepted.
   always_comb begin
      syn_next_s = lfsr_step(syn_r, din);
   end

   assign syn_next = syn_next_s;

   // Divider register: clear wins, otherwise shift on enable, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syn_r <= 3'b000;
      end else if (clr) begin
         syn_r <= 3'b000;
      end else if (en) begin
         syn_r <= syn_next_s;
      end else begin
         syn_r <= syn_r;
      end
   end

endmodule

// File: rtl/cyclic74_decoder.sv
// ---------------------------------------------------------------------------
// cyclic74_decoder
// Serial Meggitt decoder for the (7,4) cyclic code, g(x) = 1 + x + x^3.
// Bits arrive c6 first. After the 7th bit the word is handed to a correction
// stage that re-emits the corrected codeword over 7 consecutive cycles while
// the receive stage is already free for the next word.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data_in    : received code bit, sampled when in_valid = 1
//   in_valid   : data_in carries a code bit
//   data_out   : corrected code bit
//   out_valid  : data_out valid
//   word_start : marks the c6 output bit of each word
//   err_flag   : current output word was corrected (held for all 7 bits)
//   msg_out    : corrected message c6..c3, MSB = c6
//   msg_valid  : one-cycle pulse when msg_out updates
//   err_cnt    : saturating count of corrected words
// Build option:
//   CYCLIC74_ERR_STAT_EN : builds the err_cnt counter; otherwise err_cnt = 0.
// ---------------------------------------------------------------------------
module cyclic74_decoder
   import cyclic74_pkg::*;
#(
   parameter int ERR_CNT_W = 8
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 data_in,
   input  logic                 in_valid,
   output logic                 data_out,
   output logic                 out_valid,
   output logic                 word_start,
   output logic                 err_flag,
   output logic [3:0]           msg_out,
   output logic                 msg_valid,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [2:0] LAST_IDX = 3'(N - 1);
   localparam logic [2:0] MSG_BITS = 3'(K);

   // Receive stage
   logic [2:0] rx_cnt_r;
   logic [5:0] rx_buf_r;
   logic [2:0] rx_syn_next_s;
   logic       load_s;

   // Correction stage
   logic [6:0] corr_buf_r;
   syn_t       corr_syn_r;
   logic       err_word_r;
   logic [2:0] out_cnt_r;
   logic       active_r;
   logic [3:0] shadow_r;

   logic [6:0] corr_buf_nxt_s;
   syn_t       corr_syn_nxt_s;
   logic       err_word_nxt_s;
   logic [2:0] out_cnt_nxt_s;
   logic       active_nxt_s;
   logic [3:0] shadow_nxt_s;
   logic       match_s;
   logic       fix_bit_s;
   logic       msg_done_s;

   // Output registers
   logic       data_out_r;
   logic       out_valid_r;
   logic       word_start_r;
   logic       err_flag_r;
   logic [3:0] msg_out_r;
   logic       msg_valid_r;

   assign load_s = in_valid && (rx_cnt_r == LAST_IDX);

   cyclic74_syndrome u_rx_syn (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (in_valid),
      .clr      (load_s),
      .din      (data_in),
      .syn_next (rx_syn_next_s)
   );

   // Receive buffer and bit counter; both clear when the word is handed off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt_r <= 3'd0;
         rx_buf_r <= 6'd0;
      end else if (load_s) begin
         rx_cnt_r <= 3'd0;
         rx_buf_r <= 6'd0;
      end else if (in_valid) begin
         rx_cnt_r <= rx_cnt_r + 3'd1;
         rx_buf_r <= {rx_buf_r[4:0], data_in};
      end else begin
         rx_cnt_r <= rx_cnt_r;
         rx_buf_r <= rx_buf_r;
      end
   end

   // Correction stage next state. A new load wins over the last step of the
   // previous word, which keeps back-to-back words seamless.
   always_comb begin
      match_s        = (corr_syn_r == SYN_X6);
      fix_bit_s      = corr_buf_r[6] ^ match_s;
      msg_done_s     = active_r && (out_cnt_r == LAST_IDX);
      corr_buf_nxt_s = corr_buf_r;
      corr_syn_nxt_s = corr_syn_r;
      err_word_nxt_s = err_word_r;
      out_cnt_nxt_s  = out_cnt_r;
      active_nxt_s   = active_r;
      shadow_nxt_s   = shadow_r;
      if (load_s) begin
         corr_buf_nxt_s = {rx_buf_r, data_in};
         corr_syn_nxt_s = rx_syn_next_s;
         err_word_nxt_s = (rx_syn_next_s != 3'b000);
         out_cnt_nxt_s  = 3'd0;
         active_nxt_s   = 1'b1;
      end else if (active_r) begin
         corr_buf_nxt_s = {corr_buf_r[5:0], 1'b0};
         // Once the error is fixed the syndrome is zero and stays zero.
         corr_syn_nxt_s = match_s ? 3'b000 : lfsr_step(corr_syn_r, 1'b0);
         out_cnt_nxt_s  = out_cnt_r + 3'd1;
         active_nxt_s   = (out_cnt_r != LAST_IDX);
      end else begin
         active_nxt_s   = 1'b0;
      end
      if (active_r && (out_cnt_r < MSG_BITS)) begin
         shadow_nxt_s = {shadow_r[2:0], fix_bit_s};
      end else begin
         shadow_nxt_s = shadow_r;
      end
   end

   // Correction stage state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_buf_r <= 7'd0;
         corr_syn_r <= 3'b000;
         err_word_r <= 1'b0;
         out_cnt_r  <= 3'd0;
         active_r   <= 1'b0;
         shadow_r   <= 4'd0;
      end else begin
         corr_buf_r <= corr_buf_nxt_s;
         corr_syn_r <= corr_syn_nxt_s;
         err_word_r <= err_word_nxt_s;
         out_cnt_r  <= out_cnt_nxt_s;
         active_r   <= active_nxt_s;
         shadow_r   <= shadow_nxt_s;
      end
   end

   // Output registers are fed from the next correction state so the
   // corrected c6 appears in the cycle right after c0 is sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         word_start_r <= 1'b0;
         err_flag_r   <= 1'b0;
         msg_out_r    <= 4'd0;
         msg_valid_r  <= 1'b0;
      end else begin
         data_out_r   <= active_nxt_s &
                         (corr_buf_nxt_s[6] ^ (corr_syn_nxt_s == SYN_X6));
         out_valid_r  <= active_nxt_s;
         word_start_r <= active_nxt_s && (out_cnt_nxt_s == 3'd0);
         err_flag_r   <= active_nxt_s && err_word_nxt_s;
         msg_valid_r  <= msg_done_s;
         if (msg_done_s) begin
            msg_out_r <= shadow_r;
         end else begin
            msg_out_r <= msg_out_r;
         end
      end
   end

   assign data_out   = data_out_r;
   assign out_valid  = out_valid_r;
   assign word_start = word_start_r;
   assign err_flag   = err_flag_r;
   assign msg_out    = msg_out_r;
   assign msg_valid  = msg_valid_r;

`ifdef CYCLIC74_ERR_STAT_EN
   logic [ERR_CNT_W-1:0] err_cnt_r;

   // Saturating count of words that needed a correction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else if (load_s && (rx_syn_next_s != 3'b000) &&
                   (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
         err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt = err_cnt_r;
`else
   assign err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: doc/cyclic74_decoder.md
Name: cyclic74_decoder

Overview:
Serial decoder for the (7,4) cyclic code with g(x)=1+x+x^3, the receive-side counterpart of the serial encoder. It computes the syndrome of each incoming 7-bit word, corrects any single-bit error Meggitt-style, and re-emits the corrected codeword serially. It also presents the 4 message bits in parallel. Throughput is one bit per clock with back-to-back words and no stall.

Parameters:
ERR_CNT_W, 8, width of the saturating corrected-word counter (optional feature only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  1  received code bit, sampled when in_valid=1
in_valid  input  1  data_in carries a code bit this cycle
data_out  output  1  corrected code bit
out_valid  output  1  data_out valid
word_start  output  1  high with the first (c6) output bit of each word
err_flag  output  1  current output word had a correction; held for all 7 output cycles
msg_out  output  4  corrected message bits c6..c3, MSB = c6
msg_valid  output  1  one-cycle pulse when msg_out updates
err_cnt  output  ERR_CNT_W  corrected-word count (only with ERR_STAT_EN)

Behaviour:
- Bit order is fixed: c6 first, c0 last. The code is systematic, with message in c6..c3 and parity in c2..c0.
- Receive stage, per accepted bit:
  - LFSR update with fb=s2: s0<=in^fb, s1<=s0^fb, s2<=s1.
  - rx_buf shifts left; the bit counter increments 0..6.
  - When in_valid=0, all receive state holds.
- On the edge that accepts the 7th bit, the correction stage loads in the same edge:
  - corr_buf <= {rx_buf[5:0], data_in}
  - corr_syn <= next syndrome
  - err_word <= (next syndrome != 0)
  - out_cnt <= 0, active <= 1
  - The receive syndrome, rx_buf and counter all clear.
- Correction step k=0..6, one per cycle while active:
  - match = (corr_syn == 3'b101), the syndrome of an error at x^6.
  - data_out = corr_buf[6] ^ match, with out_valid=1.
  - word_start=1 only at k=0; err_flag=err_word.
  - Next state:
    - corr_buf shifts left.
    - corr_syn <= match ? 3'b000 : the LFSR shift with zero input.
    - The corrected bit is captured into msg_out shadow for k=0..3.
- After k=6, active clears.
  - The next cycle pulses msg_valid=1, and msg_out shows the corrected c6..c3.
  - msg_out holds until the next word's update.
- Latency: corrected c6 is driven in the cycle immediately after the edge that samples c0.
- Back-to-back words: the next word's load edge coincides with the end of k=6, so out_valid stays high continuously. The new load has priority, and msg_valid for the previous word still pulses.
- Gaps in in_valid stretch reception only. The correction stage always runs 7 consecutive cycles.
- Any nonzero syndrome is corrected, since the code is perfect. A word with two errors is miscorrected silently; this is required behaviour.
- Reset values:
  - Outputs: data_out, out_valid, word_start, err_flag, msg_valid, msg_out and err_cnt all reset to 0.
  - Internal state: bit counter, syndromes, buffers and active all reset to 0.
- Reset asserted mid-word discards partial input and any word in correction. No output pulse follows reset release until a full new word is received.

Optional Feature:
- Macro: CYCLIC74_ERR_STAT_EN.
- Defined:
  - err_cnt increments by 1 at each load where err_word=1, saturating at all-ones.
  - err_cnt clears only on reset.
- Undefined: err_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package cyclic74_pkg holds:
  - constants N=7, K=4
  - G_LOW=3'b011 (g coefficients x^0..x^2)
  - SYN_X6=3'b101
  - a 3-bit syndrome typedef
  - a function for one LFSR step (syn, in_bit) returning the next syndrome
- One sub-module is natural: cyclic74_syndrome, a 3-bit divider register with enable, clear and serial input. It is used in the receive stage; the correction stage uses the package function.

Test Plan:
- Reset, then words 0000000, 0001011, 1000101, 1111111 sent back-to-back:
  - data_out repeats each word 1 cycle after its last bit.
  - err_flag=0 throughout.
  - msg_out = 0000, 0001, 1000, 1111 with one msg_valid pulse each.
  - out_valid stays high for 28 continuous cycles.
- Input 0000101 (c6 flipped):
  - Corrected at k=0; output 1000101.
  - err_flag=1, msg_out=1000.
- Input 0001010 (c0 flipped):
  - Syndrome 001 reaches 101 at k=6.
  - Output 0001011, err_flag=1, msg_out=0001.
- Word 1111111 with in_valid=0 gaps of 3 cycles after bits 2 and 5:
  - Output identical to the no-gap case.
  - Output starts 1 cycle after the last accepted bit.
- rst_n pulsed low after 4 bits of 1000101, then 0001011 sent:
  - Only 0001011 appears.
  - No spurious out_valid or msg_valid.
  - err_cnt=0.
- With CYCLIC74_ERR_STAT_EN and ERR_CNT_W=2, five single-error words are sent: err_cnt goes 1, 2, 3, 3, 3.
